onehot_to_bcd: RTL and testbench

Registered one-hot to BCD encoder: converts an N-bit one-hot code into the decimal index of its set bit as a single 4-bit BCD digit. It sits between one-hot sources such as state decoders, arbiter grants or keypad scanners and BCD consumers such as seven-segment drivers and display muxes. Optional error detection flags inputs that are not strictly one-hot.

---
 rtl/onehot_bcd_pkg.sv | 11 +
 rtl/onehot_prio_enc.sv | 28 ++
 rtl/onehot_to_bcd.sv | 93 +++++++++
 tb/tb_onehot_to_bcd.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/onehot_bcd_pkg.sv
// Shared constants and types for the one-hot to BCD encoder slice.
// Used by onehot_prio_enc and onehot_to_bcd (optional checker: ONEHOT_BCD_ERR_EN).
package onehot_bcd_pkg;

    localparam int          BCD_W    = 4;
    localparam logic [3:0]  BCD_ERR  = 4'hF;
    localparam int          N_IN_MAX = 10;

    typedef logic [BCD_W-1:0] bcd_t;

endpackage : onehot_bcd_pkg

// File: rtl/onehot_prio_enc.sv
// Combinational lowest-index priority encoder with a popcount-based one-hot check.
// Pure logic; the registering and reset live in onehot_to_bcd.
module onehot_prio_enc
    import onehot_bcd_pkg::*;
#(
    parameter int N_IN = 8
) (
    input  logic [N_IN-1:0] one_hot_i,
    output bcd_t            idx_o,
    output logic            is_onehot_o
);

    bcd_t bit_count;

    // Scanning from the top down lets the lowest set bit win the last assignment.
    always_comb begin
        idx_o     = '0;
        bit_count = '0;
        for (int k = N_IN - 1; k >= 0; k--) begin
            if (one_hot_i[k]) begin
                idx_o = bcd_t'(k);
            end
            bit_count = bit_count + bcd_t'(one_hot_i[k]);
        end
        is_onehot_o = (bit_count == bcd_t'(1));
    end

endmodule : onehot_prio_enc

// File: rtl/onehot_to_bcd.sv
// Registered one-hot to BCD encoder with one cycle of latency.
// Define ONEHOT_BCD_ERR_EN to add the err output and the strict one-hot checker.
module onehot_to_bcd
    import onehot_bcd_pkg::*;
#(
    parameter int N_IN = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    input  logic [N_IN-1:0] one_hot,
    output logic [3:0]      bcd,
    output logic            out_valid
`ifdef ONEHOT_BCD_ERR_EN
    ,
    output logic            err
`endif
);

    generate
        if (N_IN < 2 || N_IN > N_IN_MAX) begin : g_bad_width
            $error("onehot_to_bcd: N_IN must lie in 2..N_IN_MAX");
        end
    endgenerate

    bcd_t enc_idx;
    logic enc_is_onehot;

    onehot_prio_enc #(
        .N_IN (N_IN)
    ) u_enc (
        .one_hot_i   (one_hot),
        .idx_o       (enc_idx),
        .is_onehot_o (enc_is_onehot)
    );

    bcd_t bcd_q, bcd_d;
    logic out_valid_q, out_valid_d;

`ifdef ONEHOT_BCD_ERR_EN
    logic err_q, err_d;

    // Non-one-hot samples replace the digit with the BCD_ERR marker.
    always_comb begin
        bcd_d       = bcd_q;
        err_d       = err_q;
        out_valid_d = in_valid;
        if (in_valid) begin
            err_d = ~enc_is_onehot;
            bcd_d = enc_is_onehot ? enc_idx : BCD_ERR;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcd_q       <= '0;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            bcd_q       <= bcd_d;
            out_valid_q <= out_valid_d;
            err_q       <= err_d;
        end
    end

    assign err = err_q;
`else
    logic is_onehot_unused;
    assign is_onehot_unused = enc_is_onehot;

    always_comb begin
        bcd_d       = bcd_q;
        out_valid_d = in_valid;
        if (in_valid) begin
            bcd_d = enc_idx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcd_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            bcd_q       <= bcd_d;
            out_valid_q <= out_valid_d;
        end
    end
`endif

    assign bcd       = bcd_q;
    assign out_valid = out_valid_q;

endmodule : onehot_to_bcd

// File: tb/tb_onehot_to_bcd.sv
// Self-checking bench for onehot_to_bcd at N_IN=8 and N_IN=10, with a behavioural model.
// Builds with or without ONEHOT_BCD_ERR_EN.
module tb_onehot_to_bcd;

    logic       clk;
    logic       rst_n;
    logic       inValid8;
    logic [7:0] oneHot8;
    logic [3:0] bcd8;
    logic       outValid8;
    logic       err8;
    logic       inValid10;
    logic [9:0] oneHot10;
    logic [3:0] bcd10;
    logic       outValid10;
    logic       err10;

    int testsRun;
    int testsFailed;

    logic [3:0] expBcd8, expBcd10;
    logic       expValid8, expValid10;
    logic       expErr8, expErr10;

    onehot_to_bcd #(.N_IN(8)) dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (inValid8),
        .one_hot   (oneHot8),
        .bcd       (bcd8),
        .out_valid (outValid8)
`ifdef ONEHOT_BCD_ERR_EN
        ,
        .err       (err8)
`endif
    );

    onehot_to_bcd #(.N_IN(10)) dut10 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (inValid10),
        .one_hot   (oneHot10),
        .bcd       (bcd10),
        .out_valid (outValid10)
`ifdef ONEHOT_BCD_ERR_EN
        ,
        .err       (err10)
`endif
    );

`ifndef ONEHOT_BCD_ERR_EN
    assign err8  = 1'b0;
    assign err10 = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: value is the position of the lowest set bit; anything not exactly one bit is an error.
    task automatic refEncode(input logic [9:0] data, input int width,
                             output logic [3:0] value, output logic isErr);
        int ones;
        int first;
        ones  = 0;
        first = -1;
        for (int i = 0; i < width; i++) begin
            if (data[i]) begin
                ones++;
                if (first < 0) first = i;
            end
        end
`ifdef ONEHOT_BCD_ERR_EN
        isErr = (ones != 1);
        value = isErr ? 4'hF : 4'(first);
`else
        isErr = 1'b0;
        value = (first < 0) ? 4'd0 : 4'(first);
`endif
    endtask

    task automatic checkOutput(input string tag, input logic [3:0] observed, input logic [3:0] expected);
        testsRun++;
        assert (observed === expected)
        else begin
            testsFailed++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic check8(input string tag);
        checkOutput({tag, " out_valid"}, {3'b0, outValid8}, {3'b0, expValid8});
        checkOutput({tag, " bcd"}, bcd8, expBcd8);
        if (expValid8) checkOutput({tag, " err"}, {3'b0, err8}, {3'b0, expErr8});
    endtask

    task automatic check10(input string tag);
        checkOutput({tag, " out_valid"}, {3'b0, outValid10}, {3'b0, expValid10});
        checkOutput({tag, " bcd"}, bcd10, expBcd10);
        if (expValid10) checkOutput({tag, " err"}, {3'b0, err10}, {3'b0, expErr10});
    endtask

    task automatic applyStimulus(input logic v, input logic [7:0] d, input string tag);
        logic [3:0] val;
        logic       e;
        @(negedge clk);
        inValid8 = v;
        oneHot8  = d;
        @(posedge clk);
        #1;
        expValid8 = v;
        if (v) begin
            refEncode({2'b00, d}, 8, val, e);
            expBcd8 = val;
            expErr8 = e;
        end
        check8(tag);
    endtask

    task automatic applyStimulus10(input logic v, input logic [9:0] d, input string tag);
        logic [3:0] val;
        logic       e;
        @(negedge clk);
        inValid10 = v;
        oneHot10  = d;
        @(posedge clk);
        #1;
        expValid10 = v;
        if (v) begin
            refEncode(d, 10, val, e);
            expBcd10 = val;
            expErr10 = e;
        end
        check10(tag);
    endtask

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        rst_n       = 1'b0;
        inValid8    = 1'b0;
        oneHot8     = '0;
        inValid10   = 1'b0;
        oneHot10    = '0;
        expBcd8     = 4'd0; expValid8  = 1'b0; expErr8  = 1'b0;
        expBcd10    = 4'd0; expValid10 = 1'b0; expErr10 = 1'b0;

        #2;
        checkOutput("reset bcd", bcd8, 4'd0);
        checkOutput("reset out_valid", {3'b0, outValid8}, 4'd0);
        checkOutput("reset err", {3'b0, err8}, 4'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int k = 0; k < 8; k++) begin
            applyStimulus(1'b1, 8'(1 << k), $sformatf("walk%0d", k));
        end

        applyStimulus(1'b1, 8'h02, "gap0");
        applyStimulus(1'b1, 8'h40, "gap1");
        applyStimulus(1'b0, 8'hFF, "gap2");
        applyStimulus(1'b1, 8'h80, "gap3");

        applyStimulus(1'b1, 8'h00, "zero");
        applyStimulus(1'b1, 8'h24, "multi");

        for (int n = 0; n < 60; n++) begin
            logic       v;
            logic [7:0] d;
            v = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 3) == 0) d = 8'($urandom);
            else d = 8'(1 << $urandom_range(0, 7));
            applyStimulus(v, d, $sformatf("rand%0d", n));
        end

        // Assert reset between edges while a result is in flight.
        @(negedge clk);
        inValid8 = 1'b1;
        oneHot8  = 8'h08;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        expBcd8 = 4'd0; expValid8 = 1'b0; expErr8 = 1'b0;
        expBcd10 = 4'd0; expValid10 = 1'b0; expErr10 = 1'b0;
        checkOutput("midreset bcd", bcd8, 4'd0);
        checkOutput("midreset out_valid", {3'b0, outValid8}, 4'd0);
        checkOutput("midreset err", {3'b0, err8}, 4'd0);
        oneHot8 = 8'h80;
        @(posedge clk);
        #1;
        check8("reset edge");
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b1, 8'h10, "post reset");
        applyStimulus(1'b0, 8'h00, "idle");

        applyStimulus10(1'b1, 10'b10_0000_0000, "n10 top");
        applyStimulus10(1'b1, 10'b00_0000_0001, "n10 bottom");
        applyStimulus10(1'b1, 10'b01_0000_0000, "n10 bit8");
        applyStimulus10(1'b1, 10'b11_0000_0000, "n10 multi");
        for (int n = 0; n < 30; n++) begin
            logic       v;
            logic [9:0] d;
            v = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 3) == 0) d = 10'($urandom);
            else d = 10'(1 << $urandom_range(0, 9));
            applyStimulus10(v, d, $sformatf("n10 rand%0d", n));
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule : tb_onehot_to_bcd
